// File: rtl/dual_core_bus_pkg.sv
// Purpose : shared types and constants for the dual-core bus arbiter.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package dual_core_bus_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Encoding of which core was granted most recently.
    localparam logic SERVED_CORE0 = 1'b0;
    localparam logic SERVED_CORE1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_grant_fsm.sv
// Purpose : ownership FSM for the shared bus (state, last_served, optional hold counter).
// Latency : request to grant 1 cycle; release to next grant 1 cycle (direct hand-off).
// Backpr. : a core holds ownership while it requests; with ARB_TIMEOUT_EN it is
//           preempted after MAX_HOLD cycles if the other core is waiting.
// Ports   : clk, reset (sync, active-low), req0/req1 in, state out.
module bus_grant_fsm
    import dual_core_bus_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    output arb_state_t state
);

    arb_state_t state_nxt;
    logic       last_served;
    logic       last_served_nxt;
    logic       hold_expired;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;

    // Counter saturates at HOLD_LAST so a late request from the waiting core
    // still triggers the hand-off on the very next edge.
    assign hold_expired = (hold_cnt == HOLD_LAST);

    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (state_nxt != state || state == IDLE) begin
            hold_cnt_nxt = '0;
        end else if (!hold_expired) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = (last_served == SERVED_CORE1) ? GNT0 : GNT1;
                end else if (req0) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!req0 || (hold_expired && req1)) begin
                    state_nxt       = req1 ? GNT1 : IDLE;
                    last_served_nxt = SERVED_CORE0;
                end
            end
            GNT1: begin
                if (!req1 || (hold_expired && req0)) begin
                    state_nxt       = req0 ? GNT0 : IDLE;
                    last_served_nxt = SERVED_CORE1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= SERVED_CORE1;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
        end
    end

endmodule

// File: rtl/dual_core_bus_arbiter.sv
// Purpose : arbitrates one memory/GPIO port between core0 and core1 and muxes the data paths.
// Latency : grant 1 cycle after request; address/data/rw/read-data paths are combinational.
// Backpr. : a non-granted core waits with its request held; no request is dropped.
// Ports   : clk, reset (sync, active-low); per core request/grant/data_in/data_out/address/rw;
//           memory side RAM_address, RAM_data_in, RAM_data_out, rw.
// Config  : define ARB_TIMEOUT_EN to force hand-off after MAX_HOLD cycles of contended ownership.
module dual_core_bus_arbiter
    import dual_core_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core0_request,
    output logic              core0_grant,
    input  logic [DATA_W-1:0] core0_data_in,
    output logic [DATA_W-1:0] core0_data_out,
    input  logic [ADDR_W-1:0] core0_address,
    input  logic              core0_rw,
    input  logic              core1_request,
    output logic              core1_grant,
    input  logic [DATA_W-1:0] core1_data_in,
    output logic [DATA_W-1:0] core1_data_out,
    input  logic [ADDR_W-1:0] core1_address,
    input  logic              core1_rw,
    output logic [ADDR_W-1:0] RAM_address,
    output logic [DATA_W-1:0] RAM_data_in,
    input  logic [DATA_W-1:0] RAM_data_out,
    output logic              rw
);

    arb_state_t state;

    bus_grant_fsm #(
        .MAX_HOLD (MAX_HOLD)
    ) u_fsm (
        .clk   (clk),
        .reset (reset),
        .req0  (core0_request),
        .req1  (core1_request),
        .state (state)
    );

    assign core0_grant = (state == GNT0);
    assign core1_grant = (state == GNT1);

    // With no owner the memory sees a read of address 0, so an idle bus can
    // never produce a spurious write.
    always_comb begin
        RAM_address    = '0;
        RAM_data_in    = '0;
        rw             = RW_READ;
        core0_data_out = '0;
        core1_data_out = '0;
        unique case (state)
            GNT0: begin
                RAM_address    = core0_address;
                RAM_data_in    = core0_data_in;
                rw             = core0_rw;
                core0_data_out = RAM_data_out;
            end
            GNT1: begin
                RAM_address    = core1_address;
                RAM_data_in    = core1_data_in;
                rw             = core1_rw;
                core1_data_out = RAM_data_out;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dual_core_bus_arbiter.sv
module tb_dual_core_bus_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          core0_request, core1_request;
    logic          core0_grant, core1_grant;
    logic [DW-1:0] core0_data_in, core1_data_in;
    logic [DW-1:0] core0_data_out, core1_data_out;
    logic [AW-1:0] core0_address, core1_address;
    logic          core0_rw, core1_rw;
    logic [AW-1:0] RAM_address;
    logic [DW-1:0] RAM_data_in;
    logic [DW-1:0] RAM_data_out;
    logic          rw;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_core_bus_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .core0_request  (core0_request),
        .core0_grant    (core0_grant),
        .core0_data_in  (core0_data_in),
        .core0_data_out (core0_data_out),
        .core0_address  (core0_address),
        .core0_rw       (core0_rw),
        .core1_request  (core1_request),
        .core1_grant    (core1_grant),
        .core1_data_in  (core1_data_in),
        .core1_data_out (core1_data_out),
        .core1_address  (core1_address),
        .core1_rw       (core1_rw),
        .RAM_address    (RAM_address),
        .RAM_data_in    (RAM_data_in),
        .RAM_data_out   (RAM_data_out),
        .rw             (rw)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rst, r0, r1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          w0, w1;
        logic [DW-1:0] rdo;
        logic          g0, g1;
        logic [AW-1:0] ra;
        logic [DW-1:0] rdi;
        logic          rw;
        logic [DW-1:0] do0, do1;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic r0, input logic r1,
        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
        input logic w0, input logic w1, input logic [DW-1:0] rdo,
        input logic g0, input logic g1, input logic [AW-1:0] ra,
        input logic [DW-1:0] rdi, input logic erw,
        input logic [DW-1:0] do0, input logic [DW-1:0] do1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.w0 = w0; v.w1 = w1; v.rdo = rdo;
        v.g0 = g0; v.g1 = g1; v.ra = ra; v.rdi = rdi; v.rw = erw;
        v.do0 = do0; v.do1 = do1;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic r0, input logic r1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic w0, input logic w1, input logic [DW-1:0] rdo);
        reset = rst; core0_request = r0; core1_request = r1;
        core0_address = a0; core1_address = a1;
        core0_data_in = d0; core1_data_in = d1;
        core0_rw = w0; core1_rw = w1; RAM_data_out = rdo;
    endtask

    task automatic check_outputs(input string tag, input logic g0, input logic g1,
                                 input logic [AW-1:0] ra, input logic [DW-1:0] rdi,
                                 input logic erw, input logic [DW-1:0] do0,
                                 input logic [DW-1:0] do1);
        check({tag, ".core0_grant"},    core0_grant,    g0);
        check({tag, ".core1_grant"},    core1_grant,    g1);
        check({tag, ".RAM_address"},    RAM_address,    ra);
        check({tag, ".RAM_data_in"},    RAM_data_in,    rdi);
        check({tag, ".rw"},             rw,             erw);
        check({tag, ".core0_data_out"}, core0_data_out, do0);
        check({tag, ".core1_data_out"}, core1_data_out, do1);
    endtask

    vec_t vecs[16];

    // Behavioural model state: owner is -1 (none), 0 or 1.
    int owner, last, held;

    initial begin
        int n_g0;
        bit saw_g1;
        logic [1:0] req;

        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);

        // rst r0 r1  a0      a1      d0     d1     w0 w1 rdo   | g0 g1 ra      rdi    rw do0    do1
        vecs[0]  = mk(0,0,0, 9'h000,9'h000, 8'h00,8'h00, 0,0, 8'h00, 0,0, 9'h000,8'h00,0, 8'h00,8'h00);
        vecs[1]  = mk(0,0,0, 9'h000,9'h000, 8'h00,8'h00, 0,0, 8'h55, 0,0, 9'h000,8'h00,0, 8'h00,8'h00);
        vecs[2]  = mk(1,0,0, 9'h000,9'h000, 8'h00,8'h00, 0,0, 8'h77, 0,0, 9'h000,8'h00,0, 8'h00,8'h00);
        vecs[3]  = mk(1,1,0, 9'h010,9'h1F0, 8'hA5,8'h99, 1,1, 8'h11, 1,0, 9'h010,8'hA5,1, 8'h11,8'h00);
        vecs[4]  = mk(1,0,0, 9'h010,9'h1F0, 8'hA5,8'h99, 1,1, 8'h11, 0,0, 9'h000,8'h00,0, 8'h00,8'h00);
        vecs[5]  = mk(0,0,0, 9'h010,9'h1F0, 8'hA5,8'h99, 1,1, 8'h11, 0,0, 9'h000,8'h00,0, 8'h00,8'h00);
        vecs[6]  = mk(1,1,1, 9'h020,9'h030, 8'h33,8'h5A, 0,1, 8'h22, 1,0, 9'h020,8'h33,0, 8'h22,8'h00);
        vecs[7]  = mk(1,0,1, 9'h020,9'h030, 8'h33,8'h5A, 0,1, 8'h44, 0,1, 9'h030,8'h5A,1, 8'h00,8'h44);
        vecs[8]  = mk(1,0,0, 9'h020,9'h030, 8'h33,8'h5A, 0,1, 8'h44, 0,0, 9'h000,8'h00,0, 8'h00,8'h00);
        vecs[9]  = mk(1,1,1, 9'h040,9'h050, 8'h01,8'h02, 0,0, 8'h66, 1,0, 9'h040,8'h01,0, 8'h66,8'h00);
        vecs[10] = mk(1,1,1, 9'h040,9'h050, 8'h01,8'h02, 0,0, 8'h66, 1,0, 9'h040,8'h01,0, 8'h66,8'h00);
        vecs[11] = mk(1,0,1, 9'h040,9'h1FF, 8'h01,8'h02, 0,0, 8'h3C, 0,1, 9'h1FF,8'h02,0, 8'h00,8'h3C);
        vecs[12] = mk(1,1,1, 9'h040,9'h1FF, 8'h01,8'h02, 0,0, 8'h3C, 0,1, 9'h1FF,8'h02,0, 8'h00,8'h3C);
        vecs[13] = mk(1,1,0, 9'h0AB,9'h1FF, 8'hC3,8'h02, 1,0, 8'h3C, 1,0, 9'h0AB,8'hC3,1, 8'h3C,8'h00);
        vecs[14] = mk(0,1,0, 9'h0AB,9'h1FF, 8'hC3,8'h02, 1,0, 8'h3C, 0,0, 9'h000,8'h00,0, 8'h00,8'h00);
        vecs[15] = mk(1,0,0, 9'h0AB,9'h1FF, 8'hC3,8'h02, 1,0, 8'h3C, 0,0, 9'h000,8'h00,0, 8'h00,8'h00);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].a1,
                  vecs[i].d0, vecs[i].d1, vecs[i].w0, vecs[i].w1, vecs[i].rdo);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].ra,
                          vecs[i].rdi, vecs[i].rw, vecs[i].do0, vecs[i].do1);
        end

        // Contended ownership: core0 wins the post-reset tie, core1 waits.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 9'h005, 9'h006, 8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; core0_request = 1'b1; core1_request = 1'b1;
        n_g0 = 0;
        saw_g1 = 1'b0;
        for (int c = 0; c < 20 && !saw_g1; c++) begin
            @(posedge clk);
            #1;
            if (core1_grant) saw_g1 = 1'b1;
            else if (core0_grant) n_g0++;
        end
        check("hold.core0_cycles", n_g0, TIMEOUT_ON ? MH : 20);
        check("hold.core1_granted", saw_g1, TIMEOUT_ON);
        check("hold.core0_grant_now", core0_grant, !TIMEOUT_ON);

        // Randomized traffic against the behavioural model.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
        owner = -1; last = 1; held = 0;
        for (int c = 0; c < 400; c++) begin
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            logic          erw;
            int            other;
            bit            preempt;
            @(negedge clk);
            reset = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 3) == 0) core0_request = ~core0_request;
            if ($urandom_range(0, 3) == 0) core1_request = ~core1_request;
            core0_address = AW'($urandom); core1_address = AW'($urandom);
            core0_data_in = DW'($urandom); core1_data_in = DW'($urandom);
            core0_rw = 1'($urandom);       core1_rw = 1'($urandom);
            RAM_data_out = DW'($urandom);
            req = {core1_request, core0_request};

            if (!reset) begin
                owner = -1; last = 1; held = 0;
            end else if (owner < 0) begin
                if (req[0] && req[1]) owner = 1 - last;
                else if (req[0]) owner = 0;
                else if (req[1]) owner = 1;
                held = (owner >= 0) ? 1 : 0;
            end else begin
                other = 1 - owner;
                preempt = TIMEOUT_ON && (held >= MH) && req[other];
                if (!req[owner] || preempt) begin
                    last = owner;
                    owner = req[other] ? other : -1;
                    held = (owner >= 0) ? 1 : 0;
                end else begin
                    held++;
                end
            end

            ea = '0; ed = '0; erw = 1'b0;
            if (owner == 0) begin ea = core0_address; ed = core0_data_in; erw = core0_rw; end
            if (owner == 1) begin ea = core1_address; ed = core1_data_in; erw = core1_rw; end

            @(posedge clk);
            #1;
            check($sformatf("rnd%0d.grants", c), {core1_grant, core0_grant},
                  {(owner == 1), (owner == 0)});
            check($sformatf("rnd%0d.ram", c), {RAM_address, RAM_data_in, rw}, {ea, ed, erw});
            check($sformatf("rnd%0d.rdata", c), {core1_data_out, core0_data_out},
                  {(owner == 1) ? RAM_data_out : 8'h00, (owner == 0) ? RAM_data_out : 8'h00});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_core_bus_arbiter.md
Name: dual_core_bus_arbiter

Overview:
- Arbitrates a single shared memory/GPIO port between two CPU cores (core0, core1).
- Grants exclusive ownership with a request/grant handshake.
- Routes the owning core's address, write data and rw to the memory side, and returns memory read data to that core.
- Sits between the two cores and the gpio memory block in the top level.

Parameters:
- ADDR_W, 9, address width for cores and memory.
- DATA_W, 8, data width for cores and memory.
- MAX_HOLD, 16, maximum consecutive grant cycles before forced hand-off; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- core0_request  input  1  core0 requests bus ownership.
- core0_grant  output  1  core0 owns the bus.
- core0_data_in  input  DATA_W  write data from core0.
- core0_data_out  output  DATA_W  read data to core0.
- core0_address  input  ADDR_W  address from core0.
- core0_rw  input  1  core0 access type (1 = write, 0 = read).
- core1_request, core1_grant, core1_data_in, core1_data_out, core1_address, core1_rw: same as core0, for core1.
- RAM_address  output  ADDR_W  address to memory.
- RAM_data_in  output  DATA_W  write data to memory.
- RAM_data_out  input  DATA_W  read data from memory.
- rw  output  1  memory access type (1 = write, 0 = read).

Behaviour:
- One clock; reset is synchronous and active-low.
- reset low at a rising clk edge:
  - state = IDLE, both grants 0, last_served = core1 (so core0 wins the first tie).
  - Hold counter = 0.
- States: IDLE, GNT0, GNT1. Grants are registered: core0_grant = (state == GNT0), core1_grant = (state == GNT1). Never both high.
- IDLE transitions:
  - Only req0 → GNT0; only req1 → GNT1.
  - Both → the core not in last_served.
  - None → stay in IDLE.
- GNT0 transitions (GNT1 symmetric):
  - Stay while core0_request = 1.
  - On core0_request = 0: go to GNT1 if core1_request = 1, else IDLE. last_served = core0.
- Latency:
  - Request to grant is 1 cycle when the bus is free.
  - Release to next grant is 1 cycle (direct hand-off, no IDLE bubble).
  - Grant drops the cycle after the request drops.
- Memory-side muxing (combinational from state):
  - GNT0: RAM_address/RAM_data_in/rw = core0 signals.
  - GNT1: RAM_address/RAM_data_in/rw = core1 signals.
  - IDLE: RAM_address = 0, RAM_data_in = 0, rw = 0 (read; no spurious writes).
- Read return (combinational): the granted core's data_out = RAM_data_out; the non-granted core's data_out = 0.
- The bus adds no pipeline delay on data paths; memory read latency is the memory's own.
- Reset asserted mid-ownership: grant drops on that edge and rw returns to 0 (write aborted).
- A request held forever keeps ownership (no starvation protection) unless ARB_TIMEOUT_EN is defined.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter increments each cycle in GNT0/GNT1 and clears on every state change.
  - When the counter reaches MAX_HOLD-1 and the other core requests, the next edge forces a switch to the other grant, even if the holder still requests.
  - The preempted core's grant drops; it must re-arbitrate.
- Undefined: no counter logic; ownership is released only by dropping the request.

Decomposition:
- Shared package dual_core_bus_pkg:
  - State enum (IDLE, GNT0, GNT1).
  - ADDR_W/DATA_W default constants.
  - RW_READ = 0, RW_WRITE = 1.
- One natural sub-module: bus_grant_fsm (state register, last_served, hold counter). The top handles the data/address muxes.

Test Plan:
- Reset low 2 cycles then high, no requests → both grants 0, RAM_address = 0, rw = 0, both data_out = 0.
- core0_request = 1, address 9'h010, rw = 1, data 8'hA5 → core0_grant = 1 the next cycle; RAM_address = 9'h010, RAM_data_in = 8'hA5, rw = 1; core1_grant = 0.
- Both requests rise in the same cycle after reset → core0 granted first. Drop req0 → core1_grant = 1 the next cycle with no IDLE cycle. Both re-request after release → core0 granted (alternation).
- core1 granted for a read at 9'h1FF, RAM_data_out = 8'h3C → core1_data_out = 8'h3C, core0_data_out = 0.
- reset low while core0 is writing → the next edge gives core0_grant = 0, rw = 0.
- With ARB_TIMEOUT_EN and MAX_HOLD = 4, core0 holds its request and core1 requests → core1_grant rises after 4 cycles of core0 ownership. Without the macro, core0 keeps the grant indefinitely.
